// File: rtl/byte_arb_pkg.sv
// Shared types and constants for the byte bank arbiter: FSM states, op encoding,
// requester index type.
package byte_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StRwait,
        StResp
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef logic req_idx_t;

    localparam req_idx_t REQ_0 = 1'b0;
    localparam req_idx_t REQ_1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: a lone request wins outright, a tie goes to the
// requester that was not granted last.
module rr_arb2
    import byte_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_grant_valid,
    output logic       o_grant_idx
);

    always_comb begin
        o_grant_valid = |i_req;
        o_grant_idx   = REQ_0;
        case (i_req)
            2'b01:   o_grant_idx = REQ_0;
            2'b10:   o_grant_idx = REQ_1;
            2'b11:   o_grant_idx = (i_last == REQ_1) ? REQ_0 : REQ_1;
            default: o_grant_idx = REQ_0;
        endcase
    end

endmodule

// File: rtl/byte_bank_arbiter.sv
// Shares a registered byte bank between two requesters with round-robin arbitration.
// Optional BYTE_ARB_ERR_EN: out-of-range addresses skip the bank and ack early with o_err.
module byte_bank_arbiter
    import byte_arb_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_op0,
    input  logic                  i_op1,
    input  logic [ADDR_W-1:0]     i_addr0,
    input  logic [ADDR_W-1:0]     i_addr1,
    input  logic [7:0]            i_wdata0,
    input  logic [7:0]            i_wdata1,
    output logic                  o_ack0,
    output logic                  o_ack1,
    output logic [7:0]            o_rdata,
    output logic                  o_err,
    output logic                  o_busy,
    output logic [NUM_REGS-1:0]   o_bank_we,
    output logic [NUM_REGS-1:0]   o_bank_re,
    output logic [7:0]            o_bank_wdata,
    input  logic [NUM_REGS*8-1:0] i_bank_q
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_grant_valid;
    logic              w_grant_idx;
    logic              w_sel_op;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [7:0]        w_sel_wdata;
    logic              w_latch;
    logic [7:0]        w_rd_byte;

    logic              r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_rdata;
    logic              r_last;

    rr_arb2 u_rr_arb2 (
        .i_req         ({i_req1, i_req0}),
        .i_last        (r_last),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    assign w_sel_op    = (w_grant_idx == REQ_1) ? i_op1    : i_op0;
    assign w_sel_addr  = (w_grant_idx == REQ_1) ? i_addr1  : i_addr0;
    assign w_sel_wdata = (w_grant_idx == REQ_1) ? i_wdata1 : i_wdata0;

`ifdef BYTE_ARB_ERR_EN
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    logic w_sel_ok;
    logic w_addr_ok;

    assign w_sel_ok  = {1'b0, w_sel_addr} < NUM_REGS_W;
    assign w_addr_ok = {1'b0, r_addr} < NUM_REGS_W;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The latched op is carried by the WRITE/READ state choice itself.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_grant_valid) begin
                    w_latch      = 1'b1;
                    w_state_next = (w_sel_op == OP_WRITE) ? StWrite : StRead;
`ifdef BYTE_ARB_ERR_EN
                    if (!w_sel_ok) begin
                        w_state_next = StResp;
                    end
`endif
                end
            end
            StWrite: w_state_next = StResp;
            StRead:  w_state_next = StRwait;
            StRwait: w_state_next = StResp;
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_owner <= REQ_0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_last  <= REQ_1;
        end else begin
            if (w_latch) begin
                r_owner <= w_grant_idx;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            if (r_state == StRwait) begin
                r_rdata <= w_rd_byte;
            end
            if (r_state == StResp) begin
                r_last <= r_owner;
            end
        end
    end

    // Out-of-range addresses match no index: no strobe, and a read yields 0.
    always_comb begin
        o_bank_we = '0;
        o_bank_re = '0;
        w_rd_byte = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (r_addr == ADDR_W'(i)) begin
                o_bank_we[i] = (r_state == StWrite);
                o_bank_re[i] = (r_state == StRead);
                w_rd_byte    = i_bank_q[8*i +: 8];
            end
        end
    end

    assign o_ack0       = (r_state == StResp) && (r_owner == REQ_0);
    assign o_ack1       = (r_state == StResp) && (r_owner == REQ_1);
    assign o_busy       = (r_state != StIdle);
    assign o_rdata      = r_rdata;
    assign o_bank_wdata = r_wdata;

`ifdef BYTE_ARB_ERR_EN
    assign o_err = (r_state == StResp) && !w_addr_ok;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_byte_bank_arbiter.sv
// Scoreboard bench for byte_bank_arbiter with a 6-entry registered bank model.
`timescale 1ns/1ps
module tb_byte_bank_arbiter;

    localparam int NREGS = 6;
    localparam int AW    = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
    logic [AW-1:0]     addr0 = '0, addr1 = '0;
    logic [7:0]        wdata0 = '0, wdata1 = '0;
    logic              ack0, ack1, err, busy;
    logic [7:0]        rdata, bank_wdata;
    logic [NREGS-1:0]  bank_we, bank_re;
    logic [NREGS*8-1:0] bank_q;

    byte_bank_arbiter #(
        .NUM_REGS (NREGS)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0       (req0),
        .i_req1       (req1),
        .i_op0        (op0),
        .i_op1        (op1),
        .i_addr0      (addr0),
        .i_addr1      (addr1),
        .i_wdata0     (wdata0),
        .i_wdata1     (wdata1),
        .o_ack0       (ack0),
        .o_ack1       (ack1),
        .o_rdata      (rdata),
        .o_err        (err),
        .o_busy       (busy),
        .o_bank_we    (bank_we),
        .o_bank_re    (bank_re),
        .o_bank_wdata (bank_wdata),
        .i_bank_q     (bank_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: write on we, output register loads only on re.
    logic [7:0] mem [NREGS];
    logic [7:0] bq  [NREGS];
    logic [7:0] shadow [NREGS];

    always @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (bank_we[i]) mem[i] <= bank_wdata;
            if (bank_re[i]) bq[i]  <= mem[i];
        end
    end

    always_comb begin
        bank_q = '0;
        for (int i = 0; i < NREGS; i++) bank_q[8*i +: 8] = bq[i];
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic       who;
        logic       upd_rd;
        logic [7:0] rdata;
        logic       err;
        int         cyc;
        int         nstb;
        int         idx;
    } exp_t;

    exp_t sb[$];

    int         stb_cnt = 0;
    int         stb_idx = 0;
    logic [7:0] model_rd = 8'h00;

    always @(negedge clk) begin
        int   ones;
        int   hit;
        exp_t e;
        logic who;
        if (rst) begin
            stb_cnt  = 0;
            model_rd = 8'h00;
        end else begin
            ones = $countones(bank_we) + $countones(bank_re);
            check("onehot", 32'((ones <= 1) && !(ack0 && ack1)), 32'd1);
            for (int i = 0; i < NREGS; i++) begin
                if (bank_we[i] || bank_re[i]) begin
                    stb_cnt++;
                    stb_idx = i;
                end
            end
            if (ack0 || ack1) begin
                who = ack1;
                hit = -1;
                foreach (sb[i]) if (hit < 0 && sb[i].who == who) hit = i;
                if (hit < 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb[hit];
                    sb.delete(hit);
                    check("ack_cycle", cyc, e.cyc);
                    if (e.upd_rd) model_rd = e.rdata;
                    check("rdata", 32'(rdata), 32'(model_rd));
                    check("err", 32'(err), 32'(e.err));
                    check("strobe_count", stb_cnt, e.nstb);
                    if (e.nstb > 0) check("strobe_index", stb_idx, e.idx);
                end
                stb_cnt = 0;
            end
        end
    end

    // Starts at #1 after a rising edge; returns at #1 after the edge following ack.
    task automatic txn(input logic who, input logic op, input logic [AW-1:0] addr,
                       input logic [7:0] wd, input int lat, input bit drop);
        exp_t e;
        bit   inr;
        bit   got;
        inr    = (addr < NREGS);
        e.who  = who;
        e.cyc  = cyc + lat;
        e.idx  = int'(addr);
        e.nstb = inr ? 1 : 0;
`ifdef BYTE_ARB_ERR_EN
        e.err  = !inr;
`else
        e.err  = 1'b0;
`endif
        e.upd_rd = (op == 1'b0) && !e.err;
        e.rdata  = inr ? shadow[addr] : 8'h00;
        if (op && inr) shadow[addr] = wd;
        sb.push_back(e);
        if (!who) begin
            req0 = 1'b1; op0 = op; addr0 = addr; wdata0 = wd;
        end else begin
            req1 = 1'b1; op1 = op; addr1 = addr; wdata1 = wd;
        end
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = who ? ack1 : ack0;
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (drop) begin
            if (!who) req0 = 1'b0;
            else      req1 = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NREGS; i++) begin
            mem[i]    = 8'(16 + i);
            shadow[i] = 8'(16 + i);
            bq[i]     = 8'h00;
        end
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(bank_we), 32'd0);
        check("rst_re", 32'(bank_re), 32'd0);
        check("rst_wdata", 32'(bank_wdata), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Write then read back through requester 0.
        txn(1'b0, 1'b1, 3'd3, 8'hA5, 2, 1'b1);
        txn(1'b0, 1'b0, 3'd3, 8'h00, 3, 1'b1);

        // Inputs change after the write is latched; bank must see the latched ones.
        fork
            txn(1'b0, 1'b1, 3'd1, 8'h3C, 2, 1'b1);
            begin
                @(posedge clk);
                #2;
                addr0  = 3'd2;
                wdata0 = 8'hFF;
            end
        join
        txn(1'b0, 1'b0, 3'd1, 8'h00, 3, 1'b1);
        txn(1'b0, 1'b0, 3'd2, 8'h00, 3, 1'b1);

        // Reset while in RWAIT: everything drops and no ack follows.
        req0 = 1'b1; op0 = 1'b0; addr0 = 3'd3;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("busy_rwait", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_acks", 32'({ack0, ack1, err, busy}), 32'd0);
        check("midrst_strobes", 32'({bank_we, bank_re}), 32'd0);
        check("midrst_data", 32'({bank_wdata, rdata}), 32'd0);
        req0 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(busy), 32'd0);
        txn(1'b0, 1'b0, 3'd3, 8'h00, 3, 1'b1);

        // Tie after requester 1 was granted last: requester 0 first.
        txn(1'b1, 1'b1, 3'd4, 8'h44, 2, 1'b1);
        fork
            txn(1'b0, 1'b1, 3'd0, 8'h70, 2, 1'b1);
            txn(1'b1, 1'b1, 3'd2, 8'h71, 5, 1'b1);
        join
        // Tie after requester 0 was granted last: requester 1 first.
        txn(1'b0, 1'b1, 3'd5, 8'h55, 2, 1'b1);
        fork
            txn(1'b0, 1'b1, 3'd0, 8'h80, 5, 1'b1);
            txn(1'b1, 1'b1, 3'd2, 8'h81, 2, 1'b1);
        join

        // Requester 1 streams four reads; requester 0 must get the second slot.
        fork
            begin
                txn(1'b1, 1'b0, 3'd0, 8'h00, 3, 1'b0);
                txn(1'b1, 1'b0, 3'd1, 8'h00, 6, 1'b0);
                txn(1'b1, 1'b0, 3'd2, 8'h00, 3, 1'b0);
                txn(1'b1, 1'b0, 3'd4, 8'h00, 3, 1'b1);
            end
            begin
                @(posedge clk);
                #1;
                txn(1'b0, 1'b1, 3'd5, 8'h5A, 5, 1'b1);
            end
        join

        // Out-of-range address 7 on a 6-entry bank.
`ifdef BYTE_ARB_ERR_EN
        txn(1'b0, 1'b0, 3'd7, 8'h00, 1, 1'b1);
        txn(1'b0, 1'b1, 3'd7, 8'hEE, 1, 1'b1);
`else
        txn(1'b0, 1'b0, 3'd7, 8'h00, 3, 1'b1);
        txn(1'b0, 1'b1, 3'd7, 8'hEE, 2, 1'b1);
`endif
        txn(1'b0, 1'b0, 3'd3, 8'h00, 3, 1'b1);
        txn(1'b1, 1'b0, 3'd5, 8'h00, 3, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
